yarp_encode: RTL and testbench

Instruction encoder: the inverse of the core's decode stage. Accepts decoded instruction fields (type, opcode, registers, functs, 32-bit immediate) over a valid/ready handshake, packs them into a 32-bit RV32I instruction word, checks that the immediate is representable for the type, and buffers results in a small FIFO. Each output word carries a byte address from an auto-incrementing counter. Used by the self-test program loader and by the verification bench to build instruction memory images.

---
 rtl/yarp_encode.sv | 131 +++++++++++++
 tb/tb_yarp_encode.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_encode.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, flags
// unrepresentable immediates, and queues results in a small addressed FIFO.
module yarp_encode #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       fld_valid_i,
    output logic                       fld_ready_o,
    input  logic [2:0]                 fld_type_i,
    input  logic [6:0]                 op_i,
    input  logic [4:0]                 rd_i,
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    input  logic [2:0]                 funct3_i,
    input  logic [6:0]                 funct7_i,
    input  logic [31:0]                imm_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [31:0]                instr_o,
    output logic [31:0]                instr_addr_o,
    output logic                       instr_err_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        T_R = 3'd0,
        T_I = 3'd1,
        T_S = 3'd2,
        T_B = 3'd3,
        T_U = 3'd4,
        T_J = 3'd5
    } fld_type_e;

    logic [31:0] enc_word;
    logic        enc_err;

    // An immediate fits when every bit above the field's sign bit copies it.
    logic sext12_ok, sext13_ok, sext21_ok;
    assign sext12_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign sext13_ok = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign sext21_ok = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (fld_type_i)
            T_R: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
            T_I: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                enc_err  = ~sext12_ok;
            end
            T_S: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
                enc_err  = ~sext12_ok;
            end
            T_B: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], op_i};
                enc_err  = ~sext13_ok | imm_i[0];
            end
            T_U: begin
                enc_word = {imm_i[31:12], rd_i, op_i};
                enc_err  = |imm_i[11:0];
            end
            T_J: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                enc_err  = ~sext21_ok | imm_i[0];
            end
            default: begin
                enc_word = '0;
                enc_err  = 1'b1;
            end
        endcase
    end

    logic [32:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   addr;
    logic          push, pop;

    // Ready comes only from the registered count, so a full FIFO cannot be
    // refilled in the same cycle it pops.
    assign fld_ready_o   = (count < CW'(DEPTH));
    assign instr_valid_o = (count != '0);
    assign push          = fld_valid_i & fld_ready_o & ~flush_i;
    assign pop           = instr_valid_o & instr_ready_i & ~flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            addr   <= BASE_ADDR;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            addr   <= BASE_ADDR;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                addr   <= addr + 32'd4;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; a slot is only read after it has
    // been written, and the head outputs are gated to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {enc_word, enc_err};
    end

    assign instr_o      = instr_valid_o ? mem[rd_ptr][32:1] : 32'h0;
    assign instr_err_o  = instr_valid_o & mem[rd_ptr][0];
    assign instr_addr_o = addr;
    assign count_o      = count;

endmodule

// File: tb/tb_yarp_encode.sv
// Self-checking bench for yarp_encode: expected words queued on push and
// compared, with the expected address, whenever the head is consumed.
module tb_yarp_encode;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_i = 1'b0;
    logic        fld_valid_i = 1'b0;
    logic        fld_ready_o;
    logic [2:0]  fld_type_i = '0;
    logic [6:0]  op_i = '0;
    logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [31:0] imm_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_err_o;
    logic [2:0]  count_o;

    yarp_encode #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .fld_valid_i(fld_valid_i), .fld_ready_o(fld_ready_o),
        .fld_type_i(fld_type_i), .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i),
        .rs2_i(rs2_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_addr_o(instr_addr_o),
        .instr_err_o(instr_err_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] sb[$];
    logic [31:0] exp_addr = BASE;
    logic [32:0] mon_e;
    vec_t        vecs[12];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] t, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] word, input logic err);
        vec_t v;
        v.t = t; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.word = word; v.err = err;
        return v;
    endfunction

    task automatic drive_fields(input vec_t v);
        fld_type_i = v.t; op_i = v.op; rd_i = v.rd; rs1_i = v.rs1;
        rs2_i = v.rs2; funct3_i = v.f3; funct7_i = v.f7; imm_i = v.imm;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input vec_t v);
        int n = 0;
        drive_fields(v);
        fld_valid_i = 1'b1;
        @(negedge clk);
        while (!fld_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!fld_ready_o) check("push_timeout", 32'd0, 32'd1);
        else sb.push_back({v.word, v.err});
        @(posedge clk); #1;
        fld_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || instr_valid_o) && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Consumer side: compare the head against the scoreboard whenever it pops.
    always @(negedge clk) begin
        if (!reset && !flush_i && instr_valid_o && instr_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("word", instr_o, mon_e[32:1]);
                check("err", 32'(instr_err_o), 32'(mon_e[0]));
                check("addr", instr_addr_o, exp_addr);
            end
            exp_addr = exp_addr + 32'd4;
        end
    end

    initial begin
        vecs[0]  = mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093, 1'b0);
        vecs[1]  = mk(3'd0, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 32'h002081B3, 1'b0);
        vecs[2]  = mk(3'd2, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423, 1'b0);
        vecs[3]  = mk(3'd3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        vecs[4]  = mk(3'd5, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd8,        32'h008000EF, 1'b0);
        vecs[5]  = mk(3'd4, 7'h37, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0);
        vecs[6]  = mk(3'd3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'd3,        32'h00208163, 1'b1);
        vecs[7]  = mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1);
        vecs[8]  = mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0);
        vecs[9]  = mk(3'd4, 7'h37, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00001001, 32'h000012B7, 1'b1);
        vecs[10] = mk(3'd6, 7'h13, 5'd1,  5'd2, 5'd3, 3'd1, 7'h20, 32'd5,        32'h00000000, 1'b1);
        vecs[11] = mk(3'd7, 7'h33, 5'd1,  5'd2, 5'd3, 3'd0, 7'h00, 32'd0,        32'h00000000, 1'b1);

        // Reset values.
        #12;
        check("rst_ready", 32'(fld_ready_o), 32'd1);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_err", 32'(instr_err_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_addr", instr_addr_o, BASE);
        @(posedge clk); #1;
        reset = 1'b0;

        // Encoding, range errors, and one-cycle latency with the consumer ready.
        instr_ready_i = 1'b1;
        foreach (vecs[i]) begin
            push(vecs[i]);
            check("latency_valid", 32'(instr_valid_o), 32'd1);
        end
        wait_drain();

        // Backpressure: four fill the FIFO, the fifth waits for space.
        do_flush();
        instr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(vecs[i]);
        check("full_ready", 32'(fld_ready_o), 32'd0);
        check("full_count", 32'(count_o), 32'd4);
        drive_fields(vecs[4]);
        fld_valid_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("held_count", 32'(count_o), 32'd4);
        check("held_ready", 32'(fld_ready_o), 32'd0);
        instr_ready_i = 1'b1;
        push(vecs[4]);
        wait_drain();
        check("bp_addr_end", instr_addr_o, BASE + 32'h14);

        // Flush with three words queued and both handshakes active.
        instr_ready_i = 1'b0;
        for (int i = 5; i < 8; i++) push(vecs[i]);
        check("pre_flush_count", 32'(count_o), 32'd3);
        drive_fields(vecs[0]);
        fld_valid_i   = 1'b1;
        instr_ready_i = 1'b1;
        flush_i       = 1'b1;
        @(negedge clk);
        check("flush_cycle_ready", 32'(fld_ready_o), 32'd1);
        @(posedge clk); #1;
        flush_i     = 1'b0;
        fld_valid_i = 1'b0;
        sb.delete();
        exp_addr = BASE;
        check("flush_count", 32'(count_o), 32'd0);
        check("flush_valid", 32'(instr_valid_o), 32'd0);
        check("flush_addr", instr_addr_o, BASE);
        @(posedge clk); #1;
        check("flush_not_stored", 32'(count_o), 32'd0);

        // Asynchronous reset in the middle of a drain.
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push(vecs[i]);
        instr_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        sb.delete();
        exp_addr = BASE;
        #1;
        check("async_valid", 32'(instr_valid_o), 32'd0);
        check("async_count", 32'(count_o), 32'd0);
        check("async_addr", instr_addr_o, BASE);
        check("async_instr", instr_o, 32'd0);
        check("async_ready", 32'(fld_ready_o), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        push(vecs[5]);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic do_flush();
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        sb.delete();
        exp_addr = BASE;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
